// File: rtl/btn_press_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_press_counter_pkg
//  Description : Shared FSM state encodings, BCD constants and a BCD
//                increment helper for the button press counter.
//  Revision    : 1.0  initial release
// ============================================================================
package btn_press_counter_pkg;

    // Debounce FSM states; the encodings are fixed so that other
    // blocks and debug views agree on them.
    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_fsm_e;

    localparam int               BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Next value of one BCD digit: 9 rolls over to 0.
    function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] d);
        return (d == BCD_MAX) ? '0 : d + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_press_counter_bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : btn_press_counter_bcd_digit
//  Description : One BCD digit with increment enable, synchronous clear and
//                combinational carry-out (asserted when incrementing a 9).
//  Revision    : 1.0  initial release
// ============================================================================
module btn_press_counter_bcd_digit
    import btn_press_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    logic [BCD_W-1:0] digit_q;

    // Digit register: reset and clear dominate, otherwise step on inc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else if (clr) begin
            digit_q <= '0;
        end else if (inc) begin
            digit_q <= bcd_next(digit_q);
        end
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/btn_press_counter.sv
`default_nettype none
// ============================================================================
//  Module      : btn_press_counter
//  Description : Stable-time debounce of a synchronized button level, a
//                single-cycle press pulse per accepted press, and a
//                NUM_DIGITS-digit BCD press counter with wrap pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_press_counter
    import btn_press_counter_pkg::*;
#(
    parameter int STABLE_CYCLES = 500000,
    parameter int NUM_DIGITS    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        btn_in,
    input  logic                        clr,
    output logic                        btn_state,
    output logic                        press_pulse,
    output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
    output logic                        wrap
);

    localparam int                   c_TIMER_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = c_TIMER_W'(STABLE_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE = c_TIMER_W'(1);

    btn_fsm_e               state_q;
    logic [c_TIMER_W-1:0]   timer_q;
    logic                   btn_state_q;
    logic                   press_pulse_q;
    logic                   wrap_q;

    logic                   w_accept;
    logic [NUM_DIGITS-1:0]  w_inc;
    logic [NUM_DIGITS-1:0]  w_carry;

    // A press is accepted on the edge that sees the (STABLE_CYCLES+1)-th
    // consecutive high sample; the counter steps on that same edge.
    assign w_accept = (state_q == PRESS_CHK) && btn_in && (timer_q == c_TIMER_MAX);

    // Debounce FSM with stability timer and registered level/pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RELEASED;
            timer_q       <= '0;
            btn_state_q   <= 1'b0;
            press_pulse_q <= 1'b0;
        end else begin
            press_pulse_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (btn_in) begin
                        state_q <= PRESS_CHK;
                        timer_q <= c_TIMER_ONE;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_in) begin
                        state_q <= RELEASED;
                        timer_q <= '0;
                    end else if (timer_q == c_TIMER_MAX) begin
                        state_q       <= PRESSED;
                        timer_q       <= '0;
                        btn_state_q   <= 1'b1;
                        press_pulse_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_in) begin
                        state_q <= RELEASE_CHK;
                        timer_q <= c_TIMER_ONE;
                    end
                end
                RELEASE_CHK: begin
                    if (btn_in) begin
                        // Release bounce: stay pressed, no new pulse.
                        state_q <= PRESSED;
                        timer_q <= '0;
                    end else if (timer_q == c_TIMER_MAX) begin
                        state_q     <= RELEASED;
                        timer_q     <= '0;
                        btn_state_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    timer_q <= '0;
                end
            endcase
        end
    end

    // Ripple-carry chain of BCD digits; digit 0 is stepped by an accept.
    assign w_inc[0] = w_accept;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        if (gi > 0) begin : g_chain
            assign w_inc[gi] = w_carry[gi-1];
        end
        btn_press_counter_bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .inc   (w_inc[gi]),
            .digit (count_bcd[gi*BCD_W +: BCD_W]),
            .carry (w_carry[gi])
        );
    end

    // Wrap pulse: carry out of the top digit, suppressed by clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= w_carry[NUM_DIGITS-1] & ~clr;
        end
    end

    assign btn_state   = btn_state_q;
    assign press_pulse = press_pulse_q;
    assign wrap        = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_press_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_press_counter
//  Description : Self-checking bench for btn_press_counter (STABLE_CYCLES=4,
//                NUM_DIGITS=2) using a run-length reference model and a
//                scoreboard queue of expected outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_press_counter;

    localparam int N  = 4;
    localparam int ND = 2;

    logic        clk;
    logic        rst_n;
    logic        btn_in;
    logic        clr;
    logic        btn_state;
    logic        press_pulse;
    logic [7:0]  count_bcd;
    logic        wrap;

    btn_press_counter #(
        .STABLE_CYCLES (N),
        .NUM_DIGITS    (ND)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .clr         (clr),
        .btn_state   (btn_state),
        .press_pulse (press_pulse),
        .count_bcd   (count_bcd),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       bs;
        logic       pp;
        logic [7:0] cnt;
        logic       wr;
    } exp_t;

    exp_t q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Observed-event tallies taken from the DUT outputs.
    int n_pulse      = 0;
    int n_wrap_pulse = 0;

    // Reference model: debounced level plus run length of disagreeing samples.
    logic m_db;
    int   m_run;
    logic m_pulse;
    int   m_cnt;
    logic m_wrap;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'((v / 10) % 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    task automatic model_step(input logic b, input logic c, input logic r);
        logic acc;
        acc = 1'b0;
        if (!r) begin
            m_db = 1'b0; m_run = 0; m_pulse = 1'b0; m_cnt = 0; m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (b != m_db) begin
                m_run++;
                if (m_run == N + 1) begin
                    m_db  = b;
                    m_run = 0;
                    acc   = b;
                end
            end else begin
                m_run = 0;
            end
            m_pulse = acc;
            if (c) begin
                m_cnt = 0;
            end else if (acc) begin
                if (m_cnt == 99) begin
                    m_cnt  = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic b, input logic c, input logic r);
        exp_t e;
        @(negedge clk);
        btn_in = b;
        clr    = c;
        rst_n  = r;
        model_step(b, c, r);
        q.push_back('{bs: m_db, pp: m_pulse, cnt: to_bcd(m_cnt), wr: m_wrap});
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("btn_state",   {7'd0, btn_state},   {7'd0, e.bs});
        check("press_pulse", {7'd0, press_pulse}, {7'd0, e.pp});
        check("count_bcd",   count_bcd,           e.cnt);
        check("wrap",        {7'd0, wrap},        {7'd0, e.wr});
        if (press_pulse === 1'b1) n_pulse++;
        if (wrap === 1'b1 && press_pulse === 1'b1) n_wrap_pulse++;
    endtask

    task automatic run(input logic b, input int cycles);
        for (int i = 0; i < cycles; i++) step(b, 1'b0, 1'b1);
    endtask

    task automatic press_once();
        run(1'b1, N + 1);
        run(1'b0, N + 1);
    endtask

    initial begin
        int p0;
        btn_in = 1'b0;
        clr    = 1'b0;
        rst_n  = 1'b0;
        m_db = 1'b0; m_run = 0; m_pulse = 1'b0; m_cnt = 0; m_wrap = 1'b0;

        // 1: reset held with button high, then a full hold is needed.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check("reset_count", count_bcd, 8'h00);
        run(1'b1, N);
        check("no_early_pulse", 8'(n_pulse), 8'd0);
        run(1'b1, 1);
        check("pulse_after_5", 8'(n_pulse), 8'd1);
        run(1'b1, 3);
        run(1'b0, 8);

        // 2: clean press.
        p0 = n_pulse;
        run(1'b1, 10);
        run(1'b0, 10);
        check("clean_press_pulses", 8'(n_pulse - p0), 8'd1);
        check("clean_press_count", count_bcd, 8'h02);

        // 3: bounce on press, then bounce on release while pressed.
        p0 = n_pulse;
        step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        run(1'b0, 3);
        check("bounce_press_none", 8'(n_pulse - p0), 8'd0);
        run(1'b1, 6);
        step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        run(1'b1, 3);
        check("bounce_release_state", {7'd0, btn_state}, 8'd1);
        run(1'b0, 6);
        check("bounce_total_pulses", 8'(n_pulse - p0), 8'd1);

        // 4: clear, count to 99, then wrap.
        step(1'b0, 1'b1, 1'b1);
        check("clr_count", count_bcd, 8'h00);
        for (int i = 0; i < 9; i++) press_once();
        check("count_09", count_bcd, 8'h09);
        press_once();
        check("carry_10", count_bcd, 8'h10);
        for (int i = 0; i < 89; i++) press_once();
        check("count_99", count_bcd, 8'h99);
        press_once();
        check("wrap_count", count_bcd, 8'h00);
        check("wrap_with_pulse", 8'(n_wrap_pulse), 8'd1);

        // 5: clear on the accept edge with count 42.
        for (int i = 0; i < 42; i++) press_once();
        check("count_42", count_bcd, 8'h42);
        run(1'b1, N);
        step(1'b1, 1'b1, 1'b1);
        check("clr_accept_count", count_bcd, 8'h00);
        check("clr_accept_pulse", {7'd0, press_pulse}, 8'd1);
        check("clr_accept_state", {7'd0, btn_state}, 8'd1);
        run(1'b1, 2);
        run(1'b0, N + 2);

        // 6: reset mid PRESS_CHK and mid PRESSED.
        run(1'b1, 3);
        step(1'b1, 1'b0, 1'b0);
        run(1'b1, N);
        p0 = n_pulse;
        run(1'b1, 1);
        check("rst_chk_pulse", 8'(n_pulse - p0), 8'd1);
        run(1'b1, 3);
        step(1'b1, 1'b0, 1'b0);
        check("rst_pressed_state", {7'd0, btn_state}, 8'd0);
        p0 = n_pulse;
        run(1'b1, N);
        check("rst_pressed_nopulse", 8'(n_pulse - p0), 8'd0);
        run(1'b1, 1);
        check("rst_pressed_pulse", 8'(n_pulse - p0), 8'd1);
        run(1'b0, N + 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
